// File: rtl/bin_to_bcd_serial_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
//   Shared definitions for the serial binary-to-BCD converter:
//     - state_t     : controller states (IDLE, SHIFT, DONE)
//     - DIGIT_W     : bits per BCD digit
//     - ADD3_THRESH : digit value at or above which the +3 correction applies
//     - ADD3_VAL    : correction added before each shift
//     - EX3_BIAS    : bias applied to form Excess-3 digits
//     - ex3_digit() : BCD digit -> Excess-3 digit
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned ADD3_VAL    = 3;
    localparam int unsigned EX3_BIAS    = 3;

    function automatic logic [DIGIT_W-1:0] ex3_digit(input logic [DIGIT_W-1:0] d);
        return d + DIGIT_W'(EX3_BIAS);
    endfunction

endpackage

// File: rtl/bin_to_bcd_serial_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3_digit
//   Combinational double-dabble correction for one BCD digit: a digit of 5
//   or more gets 3 added so that the following left shift carries correctly
//   into the next decimal digit.
//
// Ports:
//   digit_i  in  DIGIT_W  accumulator digit before correction
//   digit_o  out DIGIT_W  corrected digit (digit_i + 3 if digit_i >= 5)
// ---------------------------------------------------------------------------
module bcd_add3_digit
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    always_comb begin
        if (digit_i >= DIGIT_W'(ADD3_THRESH)) begin
            digit_o = digit_i + DIGIT_W'(ADD3_VAL);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_serial
//   Sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
//   A value accepted in IDLE is converted over exactly WIDTH SHIFT cycles,
//   then held in DONE until the consumer takes it.
//
// Parameters:
//   WIDTH   binary operand width (default 8)
//   DIGITS  BCD digits produced (default 3); requires 2^WIDTH-1 < 10^DIGITS
//           and WIDTH >= 2
//
// Ports:
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          bin_in holds a value to convert
//   in_ready   out  1          ready to accept (IDLE only)
//   bin_in     in   WIDTH      unsigned binary operand
//   out_valid  out  1          bcd_out holds a completed result (DONE)
//   out_ready  in   1          consumer accepts bcd_out
//   bcd_out    out  4*DIGITS   packed BCD, digit 0 (units) in [3:0]
//   busy       out  1          high in SHIFT or DONE
//   ex3_out    out  4*DIGITS   Excess-3 copy of bcd_out; present only when
//                              BIN2BCD_EXCESS3_OUT_EN is defined
// ---------------------------------------------------------------------------
module bin_to_bcd_serial
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
`ifdef BIN2BCD_EXCESS3_OUT_EN
    ,
    output logic [4*DIGITS-1:0]   ex3_out
`endif
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   acc_q,   acc_d;
    logic [BCD_W-1:0]   res_q,   res_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [BCD_W-1:0]         acc_corr;
    logic [BCD_W+WIDTH-1:0]   shift_full;
    logic [BCD_W-1:0]         acc_shift;
    logic [WIDTH-1:0]         bin_shift;
    logic                     last_iter;

    // Per-digit +3 correction applied to the accumulator before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (acc_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    // {accumulator, binary} shifted left as one word: the binary MSB moves
    // into the units digit LSB; the accumulator MSB falls off (always 0 for
    // legal parameter combinations).
    always_comb begin
        shift_full = {acc_corr, bin_q} << 1;
        acc_shift  = shift_full[BCD_W+WIDTH-1:WIDTH];
        bin_shift  = shift_full[WIDTH-1:0];
    end

    // Counter starts at 0 on accept, so the shift seen with cnt == WIDTH-1 is
    // the last one; the counter ends at WIDTH and never wraps.
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef BIN2BCD_EXCESS3_OUT_EN
    logic [BCD_W-1:0] ex3_q, ex3_d;
    logic [BCD_W-1:0] ex3_from_shift;

    always_comb begin
        ex3_from_shift = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            ex3_from_shift[i*DIGIT_W +: DIGIT_W] = ex3_digit(acc_shift[i*DIGIT_W +: DIGIT_W]);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
`ifdef BIN2BCD_EXCESS3_OUT_EN
        ex3_d     = ex3_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bin_d   = bin_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                busy  = 1'b1;
                acc_d = acc_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    // Result registers load from the final shift so bcd_out
                    // is already valid in the first DONE cycle and keeps its
                    // value through later conversions until the next result.
                    res_d   = acc_shift;
`ifdef BIN2BCD_EXCESS3_OUT_EN
                    ex3_d   = ex3_from_shift;
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
`ifdef BIN2BCD_EXCESS3_OUT_EN
            ex3_q   <= {DIGITS{DIGIT_W'(EX3_BIAS)}};
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef BIN2BCD_EXCESS3_OUT_EN
            ex3_q   <= ex3_d;
`endif
        end
    end

    assign bcd_out = res_q;
`ifdef BIN2BCD_EXCESS3_OUT_EN
    assign ex3_out = ex3_q;
`endif

endmodule
